// File: rtl/vga_timgen_pkg.sv
// Shared types and widths for the VGA pixel-timing generator.
package vga_timgen_pkg;

  localparam int unsigned TIMCNT_WIDTH = 12;
  localparam int unsigned TIMFIELD_W   = 10;
  localparam int unsigned DIV_W        = 8;
  localparam int unsigned VLEN_W       = 16;

  typedef enum logic [1:0] {
    TIM_SYNC       = 2'd0,
    TIM_BACKPORCH  = 2'd1,
    TIM_VISIBLE    = 2'd2,
    TIM_FRONTPORCH = 2'd3
  } timfsm_e;

  function automatic timfsm_e timfsm_next(input timfsm_e s);
    case (s)
      TIM_SYNC:      return TIM_BACKPORCH;
      TIM_BACKPORCH: return TIM_VISIBLE;
      TIM_VISIBLE:   return TIM_FRONTPORCH;
      default:       return TIM_SYNC;
    endcase
  endfunction

endpackage

// File: rtl/vga_timgen_timfsm.sv
// One timing axis: SYNC -> BACKPORCH -> VISIBLE -> FRONTPORCH, each state
// lasting (size+1) advance strobes. Used for both horizontal and vertical.
module vga_timfsm
  import vga_timgen_pkg::*;
#(
  parameter int unsigned CNT_W = TIMCNT_WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             clr_i,
  input  logic             adv_i,
  input  logic [CNT_W-1:0] sync_len_i,
  input  logic [CNT_W-1:0] bp_len_i,
  input  logic [CNT_W-1:0] vis_len_i,
  input  logic [CNT_W-1:0] fp_len_i,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] cnt_o,
  output logic             last_o
);

  timfsm_e          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt, cur_len;

  // Size of the state currently being timed
  always_comb begin
    cur_len = sync_len_i;
    case (state)
      TIM_BACKPORCH:  cur_len = bp_len_i;
      TIM_VISIBLE:    cur_len = vis_len_i;
      TIM_FRONTPORCH: cur_len = fp_len_i;
      default:        cur_len = sync_len_i;
    endcase
  end

  assign last_o  = (cnt == cur_len);
  assign state_o = state;
  assign cnt_o   = cnt;

  // Next state/count: clear holds SYNC/0, otherwise step on each advance
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (clr_i) begin
      state_nxt = TIM_SYNC;
      cnt_nxt   = '0;
    end else if (adv_i) begin
      if (last_o) begin
        state_nxt = timfsm_next(state);
        cnt_nxt   = '0;
      end else begin
        cnt_nxt = cnt + CNT_W'(1);
      end
    end
  end

  // State and in-state counter registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= TIM_SYNC;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: rtl/vga_timgen.sv
// Pixel-timing generator: pixel-clock divider, horizontal/vertical timing
// FSMs, shadowed configuration and polarity-adjusted sync/DE outputs.
module vga_timgen
  import vga_timgen_pkg::*;
#(
  parameter int unsigned CNT_W = TIMCNT_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [DIV_W-1:0]      div_i,
  input  logic                  hspol_i,
  input  logic                  vspol_i,
  input  logic                  blpol_i,
  input  logic [VLEN_W-1:0]     hvlen_i,
  input  logic [VLEN_W-1:0]     vvlen_i,
  input  logic [TIMFIELD_W-1:0] hfp_i,
  input  logic [TIMFIELD_W-1:0] hsn_i,
  input  logic [TIMFIELD_W-1:0] hbp_i,
  input  logic [TIMFIELD_W-1:0] vfp_i,
  input  logic [TIMFIELD_W-1:0] vsn_i,
  input  logic [TIMFIELD_W-1:0] vbp_i,
  output logic                  pix_req_o,
  output logic [CNT_W-1:0]      pix_x_o,
  output logic [CNT_W-1:0]      pix_y_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  de_o,
  output logic                  hend_o,
  output logic                  vend_o,
  output logic                  vbs_o
);

  logic                  en_q, run, tick, load;
  logic [DIV_W-1:0]      div_cnt, div_s;
  logic                  hspol_s, vspol_s, blpol_s;
  logic [CNT_W-1:0]      hvlen_s, vvlen_s;
  logic [TIMFIELD_W-1:0] hfp_s, hsn_s, hbp_s, vfp_s, vsn_s, vbp_s;
  logic [1:0]            hstate, vstate;
  logic [CNT_W-1:0]      hcnt, vcnt;
  logic                  hlast, vlast, hvis, vvis;

  // The first enabled clock only captures configuration; timing starts the
  // clock after, so the first tick lands on hsync/vsync line 0.
  assign run  = en_i & en_q;
  assign tick = run & (div_cnt == div_s);
  // Shadows follow the inputs while idle, so the enable edge captures them
  // and idle outputs already show the programmed polarity.
  assign load = ~en_q | vend_o;

  // Track enable to find its rising edge
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) en_q <= 1'b0;
    else          en_q <= en_i;
  end

  // Pixel divider: counts 0..div, tick on the terminal count
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  div_cnt <= '0;
    else if (!run) div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + DIV_W'(1);
  end

  // Shadow configuration; mid-frame writes wait for the next frame start
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      div_s   <= '0;
      hspol_s <= 1'b0;
      vspol_s <= 1'b0;
      blpol_s <= 1'b0;
      hvlen_s <= '0;
      vvlen_s <= '0;
      hfp_s   <= '0;
      hsn_s   <= '0;
      hbp_s   <= '0;
      vfp_s   <= '0;
      vsn_s   <= '0;
      vbp_s   <= '0;
    end else if (load) begin
      div_s   <= div_i;
      hspol_s <= hspol_i;
      vspol_s <= vspol_i;
      blpol_s <= blpol_i;
      hvlen_s <= hvlen_i[CNT_W-1:0];
      vvlen_s <= vvlen_i[CNT_W-1:0];
      hfp_s   <= hfp_i;
      hsn_s   <= hsn_i;
      hbp_s   <= hbp_i;
      vfp_s   <= vfp_i;
      vsn_s   <= vsn_i;
      vbp_s   <= vbp_i;
    end
  end

  generate
    if (CNT_W < VLEN_W) begin : g_vlen_hi
      logic unused_vlen_hi;
      assign unused_vlen_hi = ^{hvlen_i[VLEN_W-1:CNT_W], vvlen_i[VLEN_W-1:CNT_W]};
    end
  endgenerate

  vga_timfsm #(.CNT_W(CNT_W)) u_hfsm (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (~run),
    .adv_i      (tick),
    .sync_len_i (CNT_W'(hsn_s)),
    .bp_len_i   (CNT_W'(hbp_s)),
    .vis_len_i  (hvlen_s),
    .fp_len_i   (CNT_W'(hfp_s)),
    .state_o    (hstate),
    .cnt_o      (hcnt),
    .last_o     (hlast)
  );

  vga_timfsm #(.CNT_W(CNT_W)) u_vfsm (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .clr_i      (~run),
    .adv_i      (hend_o),
    .sync_len_i (CNT_W'(vsn_s)),
    .bp_len_i   (CNT_W'(vbp_s)),
    .vis_len_i  (vvlen_s),
    .fp_len_i   (CNT_W'(vfp_s)),
    .state_o    (vstate),
    .cnt_o      (vcnt),
    .last_o     (vlast)
  );

  assign hvis      = (hstate == TIM_VISIBLE);
  assign vvis      = (vstate == TIM_VISIBLE);
  assign pix_req_o = tick & hvis & vvis;
  assign pix_x_o   = hvis ? hcnt : '0;
  assign pix_y_o   = vvis ? vcnt : '0;
  assign hend_o    = tick & (hstate == TIM_FRONTPORCH) & hlast;
  assign vend_o    = hend_o & (vstate == TIM_FRONTPORCH) & vlast;
  assign vbs_o     = hend_o & vvis & vlast;

  // Registered polarity-adjusted outputs, one clock behind the state
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hsync_o <= 1'b0;
      vsync_o <= 1'b0;
      de_o    <= 1'b0;
    end else begin
      hsync_o <= (run & (hstate == TIM_SYNC)) ^ hspol_s;
      vsync_o <= (run & (vstate == TIM_SYNC)) ^ vspol_s;
      de_o    <= (run & hvis & vvis) ^ blpol_s;
    end
  end

endmodule

// File: tb/tb_vga_timgen.sv
// Directed bench for vga_timgen on a tiny frame: H sync 1/bp 1/vis N/fp 0,
// V sync 0/bp 0/vis 1/fp 0. Expected per-clock outputs come from the frame
// geometry worked out by hand (line = 2+2+(N+1)+1 ticks, frame = 5 lines).
module tb_vga_timgen;
  localparam int unsigned CNT_W = 12;

  logic             clk = 1'b0;
  logic             rst_n_i, en_i;
  logic [7:0]       div_i;
  logic             hspol_i, vspol_i, blpol_i;
  logic [15:0]      hvlen_i, vvlen_i;
  logic [9:0]       hfp_i, hsn_i, hbp_i, vfp_i, vsn_i, vbp_i;
  logic             pix_req_o, hsync_o, vsync_o, de_o, hend_o, vend_o, vbs_o;
  logic [CNT_W-1:0] pix_x_o, pix_y_o;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  vga_timgen #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .en_i(en_i), .div_i(div_i),
    .hspol_i(hspol_i), .vspol_i(vspol_i), .blpol_i(blpol_i),
    .hvlen_i(hvlen_i), .vvlen_i(vvlen_i),
    .hfp_i(hfp_i), .hsn_i(hsn_i), .hbp_i(hbp_i),
    .vfp_i(vfp_i), .vsn_i(vsn_i), .vbp_i(vbp_i),
    .pix_req_o(pix_req_o), .pix_x_o(pix_x_o), .pix_y_o(pix_y_o),
    .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
    .hend_o(hend_o), .vend_o(vend_o), .vbs_o(vbs_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {pix_req, hend, vend, vbs, hsync, vsync, de, pix_x, pix_y}
  function automatic logic [30:0] obs();
    return {pix_req_o, hend_o, vend_o, vbs_o, hsync_o, vsync_o, de_o, pix_x_o, pix_y_o};
  endfunction

  // Position of tick-unit u: first frame uses visible length hv0, later ones hv1
  function automatic void unit_pos(input int u, input int hv0, input int hv1,
                                   output int p, output int l, output int len);
    int uu;
    uu = u;
    if (uu < 5 * (hv0 + 6)) len = hv0 + 6;
    else begin
      uu  = uu - 5 * (hv0 + 6);
      len = hv1 + 6;
    end
    p = uu % len;
    l = (uu / len) % 5;
  endfunction

  // Expected outputs k clocks after the enable edge
  function automatic logic [30:0] expect_vec(input int k, input int d, input int hv0,
                                             input int hv1, input logic pol);
    int p, l, len, pp, lp, lenp, x, y;
    logic tk, hvis, vvis, req, he, ve, vb, hs, vs, de;
    tk = ((k % (d + 1)) == d);
    unit_pos(k / (d + 1), hv0, hv1, p, l, len);
    hvis = (p >= 4) && (p < len - 1);
    vvis = (l == 2) || (l == 3);
    req  = tk && hvis && vvis;
    x    = hvis ? p - 4 : 0;
    y    = vvis ? l - 2 : 0;
    he   = tk && (p == len - 1);
    ve   = he && (l == 4);
    vb   = he && (l == 3);
    if (k == 0) begin
      hs = 1'b0; vs = 1'b0; de = 1'b0;
    end else begin
      unit_pos((k - 1) / (d + 1), hv0, hv1, pp, lp, lenp);
      hs = (pp < 2);
      vs = (lp == 0);
      de = (pp >= 4) && (pp < lenp - 1) && ((lp == 2) || (lp == 3));
    end
    return {req, he, ve, vb, hs ^ pol, vs ^ pol, de ^ pol, 12'(x), 12'(y)};
  endfunction

  // Call with en_i already high and before the enable edge; checks n clocks
  task automatic run_model(input int n, input int d, input int hv0, input int hv1,
                           input int chg_at, input logic pol);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #2;
      check_eq($sformatf("d%0d hv%0d k%0d", d, hv0, k), {1'b0, obs()},
               {1'b0, expect_vec(k, d, hv0, hv1, pol)});
      if (k == chg_at) hvlen_i = 16'(hv1);
    end
  endtask

  task automatic go_idle(input int n);
    en_i = 1'b0;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    rst_n_i = 1'b0; en_i = 1'b0; div_i = 8'd0;
    hspol_i = 1'b0; vspol_i = 1'b0; blpol_i = 1'b0;
    hvlen_i = 16'd3; vvlen_i = 16'd1;
    hsn_i = 10'd1; hbp_i = 10'd1; hfp_i = 10'd0;
    vsn_i = 10'd0; vbp_i = 10'd0; vfp_i = 10'd0;
    #1;
    check_eq("reset", {1'b0, obs()}, 32'd0);
    repeat (2) @(posedge clk);
    #2 rst_n_i = 1'b1;
    repeat (2) @(posedge clk);
    #2 check_eq("idle pol0", {29'd0, hsync_o, vsync_o, de_o}, 32'd0);

    // Small frame, two frames and a bit
    en_i = 1'b1;
    run_model(100, 0, 3, 3, -1, 1'b0);

    // Enable dropped during visible (k=22 is line 2, pixel 0)
    go_idle(2);
    en_i = 1'b1;
    run_model(23, 0, 3, 3, -1, 1'b0);
    en_i = 1'b0;
    @(posedge clk); #2;
    check_eq("endrop req", {4'd0, pix_req_o, hend_o, vend_o, vbs_o, pix_x_o, pix_y_o}, 32'd0);
    @(posedge clk); #2;
    check_eq("endrop sync", {29'd0, hsync_o, vsync_o, de_o}, 32'd0);
    en_i = 1'b1;
    run_model(30, 0, 3, 3, -1, 1'b0);

    // Reset pulse during visible (k=24 is line 2, pixel 2)
    go_idle(2);
    en_i = 1'b1;
    run_model(25, 0, 3, 3, -1, 1'b0);
    rst_n_i = 1'b0;
    #1 check_eq("rst async", {1'b0, obs()}, 32'd0);
    @(negedge clk) rst_n_i = 1'b1;
    run_model(30, 0, 3, 3, -1, 1'b0);

    // Divider by 3
    en_i = 1'b0;
    div_i = 8'd2;
    go_idle(2);
    en_i = 1'b1;
    run_model(145, 2, 3, 3, -1, 1'b0);

    // All polarities inverted
    en_i = 1'b0;
    div_i = 8'd0;
    hspol_i = 1'b1; vspol_i = 1'b1; blpol_i = 1'b1;
    go_idle(3);
    check_eq("idle pol1", {29'd0, hsync_o, vsync_o, de_o}, 32'd7);
    en_i = 1'b1;
    run_model(50, 0, 3, 3, -1, 1'b1);

    // Mid-frame visible-length change applies from the next frame
    en_i = 1'b0;
    hspol_i = 1'b0; vspol_i = 1'b0; blpol_i = 1'b0;
    go_idle(3);
    en_i = 1'b1;
    run_model(120, 0, 3, 7, 20, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
